ternary_array_ctrl: RTL and testbench

- Sequencer for a ROWS x COLS weight-stationary ternary PE systolic array built from integer-interface PEs.
- Loads one weight row per beat into the array, streams activation vectors with whole-array stall on starvation, drains the pipeline with zero activations, and flags result beats at the array's south edge.
- Sits between the TPU command/DMA front end and the array. External skew buffers are outside this block.

---
 rtl/ternary_array_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ternary_array_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_array_ctrl.sv
// ternary_array_ctrl
//   Sequencer for a ROWS x COLS weight-stationary ternary PE systolic array.
//   A job loads ROWS weight-row beats (unless resident weights are reused),
//   streams num_vec activation vectors, then drains the pipeline with zero
//   activations. A LAT-deep tag shift register follows each accepted vector
//   through the array so the south-edge result beats can be flagged.
//
// Handshake: a beat transfers in any cycle where valid & ready are both 1.
//   valid may be held across cycles; ready never depends on valid, and the
//   two ready outputs (w_ready, act_ready) are never asserted together.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               launch pulse, honoured only in IDLE
//   cfg_num_vec         activation vectors in the job (latched on start)
//   cfg_skip_wload      reuse resident weights, bypass LOAD_W
//   w_valid/w_ready     weight-row beat handshake, w_data = 2-bit codes
//                       (00=-1, 01=0, 10=+1, 11 illegal)
//   act_valid/act_ready activation vector handshake
//   pe_wload            one-hot row weight-load strobe (one cycle after beat)
//   pe_weight           sanitised row weights for the strobed row
//   array_en            enable to all PEs; 0 stalls the whole array
//   act_zero            force zero activations (drain)
//   res_valid           south-edge result beat valid
//   busy, done          state != IDLE, one-cycle completion pulse
//   err_wcode           sticky illegal weight code flag
//   state_dbg           current FSM state encoding (debug)
//
// Optional: define TPU_CTRL_PERF_CNT_EN to add saturating perf counters
//   perf_stall, perf_zero_w, perf_cycles.
module ternary_array_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int LAT   = ROWS + COLS - 1,
    parameter int VEC_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [VEC_W-1:0]    cfg_num_vec,
    input  logic                cfg_skip_wload,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [2*COLS-1:0]   w_data,
    input  logic                act_valid,
    output logic                act_ready,
    output logic [ROWS-1:0]     pe_wload,
    output logic [2*COLS-1:0]   pe_weight,
    output logic                array_en,
    output logic                act_zero,
    output logic                res_valid,
    output logic                busy,
    output logic                done,
    output logic                err_wcode,
    output logic [2:0]          state_dbg
`ifdef TPU_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall,
    output logic [31:0]         perf_zero_w,
    output logic [31:0]         perf_cycles
`endif
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [RW-1:0]       row_cnt;
    logic [VEC_W-1:0]    vec_cnt;
    logic [VEC_W-1:0]    num_vec;
    logic [LAT-1:0]      tag;
    logic [LAT-1:0]      tag_drain;
    logic [2*COLS-1:0]   w_san;
    logic                w_bad;
    logic                w_fire;
    logic                act_fire;
    logic                start_acc;

    // Illegal 11 codes are replaced by the zero weight (01).
    always_comb begin
        w_san = w_data;
        w_bad = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (w_data[2*c +: 2] == 2'b11) begin
                w_san[2*c +: 2] = 2'b01;
                w_bad           = 1'b1;
            end
        end
    end

    assign w_ready   = (state == LOAD_W);
    assign act_ready = (state == COMPUTE) && (vec_cnt < num_vec);
    assign w_fire    = w_valid & w_ready;
    assign act_fire  = act_valid & act_ready;
    assign start_acc = (state == IDLE) && start;
    assign array_en  = act_fire | (state == DRAIN);
    assign act_zero  = (state == DRAIN);
    assign res_valid = array_en & tag[LAT-1];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;
    // Tag contents after a drain shift; all-zero means the last result
    // leaves the array this cycle.
    assign tag_drain = {tag[LAT-2:0], 1'b0};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = cfg_skip_wload ? COMPUTE : LOAD_W;
            LOAD_W:  if (w_fire && row_cnt == RW'(ROWS - 1)) state_nxt = COMPUTE;
            COMPUTE: if (vec_cnt == num_vec)
                         state_nxt = (num_vec == '0) ? DONE : DRAIN;
            DRAIN:   if (tag_drain == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            vec_cnt   <= '0;
            num_vec   <= '0;
            tag       <= '0;
            pe_wload  <= '0;
            pe_weight <= '0;
            err_wcode <= 1'b0;
        end else begin
            state    <= state_nxt;
            pe_wload <= w_fire ? (ROWS'(1) << row_cnt) : '0;
            if (start_acc) begin
                num_vec <= cfg_num_vec;
                vec_cnt <= '0;
                row_cnt <= '0;
            end
            if (w_fire) begin
                pe_weight <= w_san;
                row_cnt   <= row_cnt + 1'b1;
            end
            if (w_fire && w_bad) err_wcode <= 1'b1;
            if (act_fire) vec_cnt <= vec_cnt + 1'b1;
            // The tag moves with the array: frozen while stalled.
            if (array_en) tag <= {tag[LAT-2:0], act_fire};
        end
    end

`ifdef TPU_CTRL_PERF_CNT_EN
    logic [31:0] zero_in_beat;

    always_comb begin
        zero_in_beat = '0;
        for (int c = 0; c < COLS; c++) begin
            if (w_san[2*c +: 2] == 2'b01) zero_in_beat = zero_in_beat + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            perf_stall  <= '0;
            perf_zero_w <= '0;
            perf_cycles <= '0;
        end else begin
            if (act_ready && !act_valid && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
            if (w_fire) begin
                // Saturating add of the per-beat zero count.
                if (perf_zero_w > 32'hFFFF_FFFF - zero_in_beat)
                    perf_zero_w <= 32'hFFFF_FFFF;
                else
                    perf_zero_w <= perf_zero_w + zero_in_beat;
            end
            if (busy && perf_cycles != 32'hFFFF_FFFF)
                perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ternary_array_ctrl.sv
// tb_ternary_array_ctrl
//   Directed bench for ternary_array_ctrl with ROWS=COLS=4, LAT=7.
//   Drivers push expected weight strobes and expected result enable-cycle
//   indices into queues; a negedge monitor pops and compares them.
module tb_ternary_array_ctrl;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int LAT   = 7;
    localparam int VEC_W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [VEC_W-1:0]    cfg_num_vec;
    logic                cfg_skip_wload;
    logic                w_valid;
    logic                w_ready;
    logic [2*COLS-1:0]   w_data;
    logic                act_valid;
    logic                act_ready;
    logic [ROWS-1:0]     pe_wload;
    logic [2*COLS-1:0]   pe_weight;
    logic                array_en;
    logic                act_zero;
    logic                res_valid;
    logic                busy;
    logic                done;
    logic                err_wcode;
    logic [2:0]          state_dbg;
`ifdef TPU_CTRL_PERF_CNT_EN
    logic [31:0]         perf_stall;
    logic [31:0]         perf_zero_w;
    logic [31:0]         perf_cycles;
`endif

    ternary_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .LAT(LAT), .VEC_W(VEC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_vec(cfg_num_vec),
        .cfg_skip_wload(cfg_skip_wload), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .act_valid(act_valid), .act_ready(act_ready),
        .pe_wload(pe_wload), .pe_weight(pe_weight), .array_en(array_en),
        .act_zero(act_zero), .res_valid(res_valid), .busy(busy), .done(done),
        .err_wcode(err_wcode), .state_dbg(state_dbg)
`ifdef TPU_CTRL_PERF_CNT_EN
        , .perf_stall(perf_stall), .perf_zero_w(perf_zero_w), .perf_cycles(perf_cycles)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_COMP = 3'd2,
                           S_DRAIN = 3'd3, S_DONE = 3'd4;

    // ---------------- scoreboard ----------------
    logic [31:0]              exp_q[$];   // expected enable-cycle index of each result
    logic [ROWS+2*COLS-1:0]   w_q[$];     // expected {pe_wload, pe_weight}
    int checks   = 0;
    int failures = 0;
    int en_idx   = 0;
    int res_cnt  = 0;
    int done_cnt = 0;
    int busy_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*COLS-1:0] sanitise(input logic [2*COLS-1:0] d);
        logic [2*COLS-1:0] s;
        s = d;
        for (int c = 0; c < COLS; c++)
            if (d[2*c +: 2] == 2'b11) s[2*c +: 2] = 2'b01;
        return s;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (exp_q.size() == 0) chk("res_unexpected", 32'(en_idx), 32'hFFFF_FFFF);
                else chk("res_timing", 32'(en_idx), exp_q.pop_front());
                res_cnt++;
            end
            if (array_en) en_idx++;
            if (pe_wload != '0) begin
                if (w_q.size() == 0) chk("wload_unexpected", 32'({pe_wload, pe_weight}), 32'h0);
                else chk("wload_beat", 32'({pe_wload, pe_weight}), 32'(w_q.pop_front()));
            end
            if (done) done_cnt++;
            if (busy) busy_cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int nv, input logic skip);
        start = 1'b1;
        cfg_num_vec = VEC_W'(nv);
        cfg_skip_wload = skip;
        tick();
        start = 1'b0;
        cfg_num_vec = 16'hBEEF;     // mid-job config changes must be ignored
        cfg_skip_wload = ~skip;
        chk("state_after_start", 32'(state_dbg), skip ? 32'(S_COMP) : 32'(S_LOAD));
    endtask

    task automatic load_rows(input logic [2*COLS-1:0] r0, input logic [2*COLS-1:0] r1,
                             input logic [2*COLS-1:0] r2, input logic [2*COLS-1:0] r3);
        logic [2*COLS-1:0] rows [4];
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        for (int r = 0; r < ROWS; r++) begin
            w_valid = 1'b1;
            w_data  = rows[r];
            #1;
            chk("w_ready", 32'(w_ready), 32'd1);
            chk("act_ready_in_load", 32'(act_ready), 32'd0);
            w_q.push_back({ROWS'(1) << r, sanitise(rows[r])});
            @(posedge clk);
            #1;
        end
        w_valid = 1'b0;
    endtask

    // Drives act_valid from pat[0..len-1]; bench tracks its own vector count.
    task automatic stream(input logic [15:0] pat, input int len, input int nv);
        int bvec = 0;
        for (int i = 0; i < len; i++) begin
            act_valid = pat[i];
            #1;
            chk("act_ready", 32'(act_ready), 32'(bvec < nv));
            chk("array_en", 32'(array_en), 32'(pat[i] && bvec < nv));
            chk("w_ready_in_compute", 32'(w_ready), 32'd0);
            if (pat[i] && bvec < nv) begin
                exp_q.push_back(32'(en_idx + LAT));
                bvec++;
            end
            @(posedge clk);
            #1;
        end
        act_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("idle_after_done", 32'(state_dbg), 32'(S_IDLE));
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        chk("rst_pe_wload", 32'(pe_wload), 32'd0);
        chk("rst_pe_weight", 32'(pe_weight), 32'd0);
        chk("rst_array_en", 32'(array_en), 32'd0);
        chk("rst_act_zero", 32'(act_zero), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_wcode", 32'(err_wcode), 32'd0);
        chk("rst_ready", 32'({w_ready, act_ready}), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r0, d0, n;
        rst = 1'b1; start = 1'b0; cfg_num_vec = '0; cfg_skip_wload = 1'b0;
        w_valid = 1'b0; w_data = '0; act_valid = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b0;
        tick();

        // Job A: full load, 3 vectors, no stalls.
        r0 = res_cnt; d0 = done_cnt; busy_cyc = 0;
        start_job(3, 1'b0);
        load_rows(8'b10_01_00_10, 8'b01_01_01_01, 8'b00_10_10_00, 8'b10_00_01_10);
        stream(16'b111, 3, 3);
        wait_done(d0);
        chk("A_res_count", 32'(res_cnt - r0), 32'd3);
        chk("A_err_wcode", 32'(err_wcode), 32'd0);
`ifdef TPU_CTRL_PERF_CNT_EN
        chk("A_perf_zero_w", perf_zero_w, 32'd6);
        chk("A_perf_stall", perf_stall, 32'd0);
        chk("A_perf_cycles", perf_cycles, 32'(busy_cyc));
`endif

        // Job B: resident weights, stalled stream, start and w_valid held
        // high throughout (both must be ignored).
        r0 = res_cnt; d0 = done_cnt;
        start_job(3, 1'b1);
        start = 1'b1; cfg_num_vec = 16'd9; w_valid = 1'b1; w_data = 8'hFF;
        stream(16'b11001, 5, 3);
        chk("B_no_wload", 32'(pe_wload), 32'd0);
        chk("B_err_untouched", 32'(err_wcode), 32'd0);
        start = 1'b0; w_valid = 1'b0;
        wait_done(d0);
        chk("B_res_count", 32'(res_cnt - r0), 32'd3);
`ifdef TPU_CTRL_PERF_CNT_EN
        chk("B_perf_stall", perf_stall, 32'd2);
        chk("B_perf_zero_w", perf_zero_w, 32'd0);
`endif

        // Job C: illegal code 11 in column 2 of row 1.
        r0 = res_cnt; d0 = done_cnt;
        start_job(1, 1'b0);
        load_rows(8'b10_10_10_10, 8'b00_11_00_10, 8'b00_00_00_00, 8'b01_00_10_00);
        chk("C_err_wcode", 32'(err_wcode), 32'd1);
        stream(16'b1, 1, 1);
        wait_done(d0);
        chk("C_res_count", 32'(res_cnt - r0), 32'd1);
`ifdef TPU_CTRL_PERF_CNT_EN
        chk("C_perf_zero_w", perf_zero_w, 32'd2);
`endif

        // Job D: skip load with zero vectors.
        r0 = res_cnt; d0 = done_cnt;
        start_job(0, 1'b1);
        tick();
        chk("D_state_done", 32'(state_dbg), 32'(S_DONE));
        chk("D_done", 32'(done), 32'd1);
        tick();
        chk("D_idle", 32'(state_dbg), 32'(S_IDLE));
        chk("D_res_count", 32'(res_cnt - r0), 32'd0);
        chk("D_err_sticky", 32'(err_wcode), 32'd1);

        // Job E: reset in the middle of DRAIN.
        start_job(2, 1'b1);
        stream(16'b11, 2, 2);
        n = 0;
        while (state_dbg != S_DRAIN && n < 20) begin tick(); n++; end
        chk("E_in_drain", 32'(state_dbg), 32'(S_DRAIN));
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst = 1'b0;
        exp_q.delete();
        w_q.delete();

        // Job F: clean run after the reset.
        r0 = res_cnt; d0 = done_cnt;
        start_job(2, 1'b1);
        stream(16'b101, 3, 2);
        wait_done(d0);
        chk("F_res_count", 32'(res_cnt - r0), 32'd2);

        tick();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("w_q_empty", 32'(w_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
